hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Parametrised successor to the 5-stage pipeline's forwarding controller; sits beside the datapath in the mips top level.
- Adds ID-stage branch-operand forwarding, load-use and branch stalls, F/D/E flush control and a multi-cycle MULT/DIV interlock.
- Adds a saturating stall-cycle performance counter.
- Datapath consumes Stall*/Flush*/Forward* directly; no handshake beyond these level signals.

Parameters:
- REG_ADDR_W, 5, register-address width; address 0 is the hard-wired zero register and is never forwarded or interlocked.
- MD_LATENCY, 4, EX-stage cycles a MULT/DIV occupies (>=1); HI/LO readable MD_LATENCY cycles after issue.
- CNT_W, 32, width of stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- RsD, RtD  in  REG_ADDR_W each  source registers of instruction in Decode.
- RsE, RtE  in  REG_ADDR_W each  source registers in Execute.
- WriteRegE, WriteRegM, WriteRegW  in  REG_ADDR_W each  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enable per stage.
- MemtoRegE, MemtoRegM  in  1 each  instruction is a load.
- BranchD  in  1  Decode holds a conditional branch.
- PCSrcD  in  1  branch resolved taken in Decode.
- JumpD  in  1  Decode holds a jump.
- MdStartE  in  1  MULT/DIV entering Execute this cycle (single-cycle pulse).
- MdUseD  in  1  Decode holds MFHI/MFLO or another MULT/DIV.
- ForwardAE, ForwardBE  out  2 each  EX operand select.
- ForwardAD, ForwardBD  out  1 each  ID compare operand from ALUOutM.
- StallF, StallD  out  1 each  hold PC / IF-ID register.
- FlushD, FlushE  out  1 each  clear IF-ID / ID-EX register.
- MdBusy  out  1  multi-cycle unit occupied.
- StallCount  out  CNT_W  cycles with StallF=1 since reset.

Behaviour:
- nz(x) means x != 0.
- ForwardAE = FWD_MEM (2'b10) if RegWriteM & nz(WriteRegM) & WriteRegM==RsE; else FWD_WB (2'b01) if RegWriteW & nz(WriteRegW) & WriteRegW==RsE; else FWD_NONE (2'b00). M has priority over W. ForwardBE identical with RtE.
- ForwardAD = RegWriteM & nz(WriteRegM) & WriteRegM==RsD; ForwardBD likewise with RtD.
- lwstall = MemtoRegE & nz(WriteRegE) & (WriteRegE==RsD | WriteRegE==RtD).
- branchstall = BranchD & [ (RegWriteE & nz(WriteRegE) & WriteRegE∈{RsD,RtD}) | (MemtoRegM & nz(WriteRegM) & WriteRegM∈{RsD,RtD}) ].
- MD counter md_cnt (width clog2(MD_LATENCY)+1):
  - Async reset to 0.
  - On MdStartE, load MD_LATENCY-1; else if nz(md_cnt), decrement.
  - MdBusy = nz(md_cnt).
  - MD_LATENCY=1 gives MdBusy constantly 0.
  - MdStartE while busy reloads the counter (restart).
- mdstall = MdUseD & (MdBusy | MdStartE).
- stall = lwstall | branchstall | mdstall.
- StallF = StallD = FlushE = stall. FlushE inserts a bubble into E.
- FlushD = (PCSrcD | JumpD) & ~stall. A stalled branch does not flush until resolved.
- StallCount:
  - Async reset to 0.
  - +1 on each rising edge where StallF=1; saturates at all-ones.
- Reset values: MdBusy=0, StallCount=0. With reset low, all stall/flush/forward outputs are driven purely by their inputs, with md terms 0.
- Forward/stall/flush outputs are combinational, zero latency.
- Reset asserted mid-MD operation clears md_cnt immediately.

Decomposition:
- Package mips_hazard_pkg holds:
  - FWD_NONE/FWD_WB/FWD_MEM localparams.
  - The 2-bit forward-select typedef.
  - Default REG_ADDR_W.
- One natural sub-module, hazard_fwd_sel: combinational 2-level priority match (src, M dest/we, W dest/we → 2-bit select). Instanced for A and B.

Test Plan:
- RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 → ForwardAE=10. Repeat with WriteRegM=5 → 01. Repeat with all dests=0 → 00.
- Load to r4 in E (MemtoRegE=1, WriteRegE=4), RtD=4 → StallF=StallD=FlushE=1 for 1 cycle; StallCount 0→1.
- BranchD=1, RsD=7, RegWriteE=1, WriteRegE=7 → stall 1 cycle. Next cycle, with the value in M, ForwardAD=1 and stall=0. PCSrcD=1 then → FlushD=1.
- MD_LATENCY=4: MdStartE pulse → MdBusy high 3 cycles. MdUseD held high → stall for those 3 cycles plus the issue cycle, then released; StallCount +4.
- JumpD=1 with stall=1 → FlushD=0. With stall=0 → FlushD=1.
- Assert reset low while md_cnt=2 and StallCount=9 → MdBusy=0, StallCount=0 immediately, without waiting for a clock edge.
- Force StallF=1 for 2^CNT_W cycles, CNT_W=4 → StallCount holds 15.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Forward-select encodings are consumed directly by the EX operand muxes.
package mips_hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef logic [1:0] fwdSel_t;

  localparam fwdSel_t FWD_NONE = 2'b00;
  localparam fwdSel_t FWD_WB   = 2'b01;
  localparam fwdSel_t FWD_MEM  = 2'b10;

endpackage

// File: rtl/hazard_unit_if.sv
// Level-signal bundle between the datapath and the hazard unit.
// Latency: none (pure wires); no backpressure, the datapath obeys Stall/Flush levels.
interface hazard_unit_if
  import mips_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] RsD;
  logic [REG_ADDR_W-1:0] RtD;
  logic [REG_ADDR_W-1:0] RsE;
  logic [REG_ADDR_W-1:0] RtE;
  logic [REG_ADDR_W-1:0] WriteRegE;
  logic [REG_ADDR_W-1:0] WriteRegM;
  logic [REG_ADDR_W-1:0] WriteRegW;
  logic                  RegWriteE;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  MemtoRegE;
  logic                  MemtoRegM;
  logic                  BranchD;
  logic                  PCSrcD;
  logic                  JumpD;
  logic                  MdStartE;
  logic                  MdUseD;

  fwdSel_t               ForwardAE;
  fwdSel_t               ForwardBE;
  logic                  ForwardAD;
  logic                  ForwardBD;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic                  MdBusy;
  logic [CNT_W-1:0]      StallCount;

  // Datapath side: presents pipeline state, consumes control levels.
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, PCSrcD, JumpD, MdStartE, MdUseD,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    input  StallF, StallD, FlushD, FlushE, MdBusy, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcD, JumpD, MdStartE, MdUseD,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    output StallF, StallD, FlushD, FlushE, MdBusy, StallCount
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// EX operand forward select: MEM result beats WB result, r0 never forwarded.
// Latency: combinational; no backpressure.
module hazard_fwd_sel
  import mips_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] destM,
  input  logic                  weM,
  input  logic [REG_ADDR_W-1:0] destW,
  input  logic                  weW,
  output fwdSel_t               sel
);

  logic hitM;
  logic hitW;

  assign hitM = weM && (destM != '0) && (destM == src);
  assign hitW = weW && (destW != '0) && (destW == src);

  always_comb begin
    sel = FWD_NONE;
    if (hitM) begin
      sel = FWD_MEM;
    end else if (hitW) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use/branch/MULT-DIV stalls, flushes, stall counter.
// Latency: control outputs combinational; MdBusy/StallCount registered. No backpressure.
module hazard_unit
  import mips_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hz
);

  localparam int MD_CNT_W = $clog2(MD_LATENCY) + 1;
  localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);

  logic [MD_CNT_W-1:0] mdCnt;
  logic [CNT_W-1:0]    stallCnt;

  logic mdBusy;
  logic hitE;
  logic hitMD;
  logic lwStall;
  logic branchStall;
  logic mdStall;
  logic stall;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
    .src   (hz.RsE),
    .destM (hz.WriteRegM),
    .weM   (hz.RegWriteM),
    .destW (hz.WriteRegW),
    .weW   (hz.RegWriteW),
    .sel   (hz.ForwardAE)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
    .src   (hz.RtE),
    .destM (hz.WriteRegM),
    .weM   (hz.RegWriteM),
    .destW (hz.WriteRegW),
    .weW   (hz.RegWriteW),
    .sel   (hz.ForwardBE)
  );

  // Branch comparator in ID can only take ALUOutM; W values arrive via the regfile.
  assign hz.ForwardAD = hz.RegWriteM && (hz.WriteRegM != '0) && (hz.WriteRegM == hz.RsD);
  assign hz.ForwardBD = hz.RegWriteM && (hz.WriteRegM != '0) && (hz.WriteRegM == hz.RtD);

  // Decode sources that match the E / M destinations (r0 excluded).
  assign hitE  = (hz.WriteRegE != '0) &&
                 ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
  assign hitMD = (hz.WriteRegM != '0) &&
                 ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD));

  assign lwStall     = hz.MemtoRegE && hitE;
  assign branchStall = hz.BranchD && ((hz.RegWriteE && hitE) || (hz.MemtoRegM && hitMD));

  // A MULT/DIV issuing this cycle already blocks a dependent instruction in D.
  assign mdBusy  = (mdCnt != '0);
  assign mdStall = hz.MdUseD && (mdBusy || hz.MdStartE);

  assign stall = lwStall || branchStall || mdStall;

  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;
  // A stalled branch/jump must not discard the fetched slot until it resolves.
  assign hz.FlushD = (hz.PCSrcD || hz.JumpD) && !stall;

  assign hz.MdBusy     = mdBusy;
  assign hz.StallCount = stallCnt;

  // Restart on a new issue even while still busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdCnt <= '0;
    end else if (hz.MdStartE) begin
      mdCnt <= MD_RELOAD;
    end else if (mdBusy) begin
      mdCnt <= mdCnt - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed + randomized check of hazard_unit against a rule-level reference model.
module tb_hazard_unit;
  import mips_hazard_pkg::*;

  localparam int AW   = 5;
  localparam int MDL  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hIf ();

  hazard_unit #(.REG_ADDR_W(AW), .MD_LATENCY(MDL), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hIf.slave)
  );

  int errors = 0;
  int checks = 0;
  bit cmpEn  = 1'b0;

  // Reference state: remaining busy cycles of the MULT/DIV unit and stall tally.
  int mdRem  = 0;
  int cntExp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit writesTo(input bit we, input int dest, input int r);
    return we && dest != 0 && dest == r;
  endfunction

  function automatic int expFwdE(input int src);
    if (writesTo(hIf.RegWriteM, int'(hIf.WriteRegM), src)) return 2;
    if (writesTo(hIf.RegWriteW, int'(hIf.WriteRegW), src)) return 1;
    return 0;
  endfunction

  function automatic bit readsInD(input int r);
    return r != 0 && (r == int'(hIf.RsD) || r == int'(hIf.RtD));
  endfunction

  function automatic bit modelStall();
    bit lw, br, md;
    lw = hIf.MemtoRegE && readsInD(int'(hIf.WriteRegE));
    br = hIf.BranchD && ((hIf.RegWriteE && readsInD(int'(hIf.WriteRegE))) ||
                         (hIf.MemtoRegM && readsInD(int'(hIf.WriteRegM))));
    md = hIf.MdUseD && (mdRem > 0 || hIf.MdStartE);
    return lw || br || md;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit s;
    if (!reset) begin
      mdRem  = 0;
      cntExp = 0;
    end else begin
      s = modelStall();
      if (hIf.MdStartE) mdRem = MDL - 1;
      else if (mdRem > 0) mdRem--;
      if (s && cntExp < CMAX) cntExp++;
    end
  end

  always @(negedge clk) begin
    bit s;
    if (cmpEn) begin
      s = modelStall();
      chk("ForwardAE", hIf.ForwardAE, expFwdE(int'(hIf.RsE)));
      chk("ForwardBE", hIf.ForwardBE, expFwdE(int'(hIf.RtE)));
      chk("ForwardAD", hIf.ForwardAD, writesTo(hIf.RegWriteM, int'(hIf.WriteRegM), int'(hIf.RsD)));
      chk("ForwardBD", hIf.ForwardBD, writesTo(hIf.RegWriteM, int'(hIf.WriteRegM), int'(hIf.RtD)));
      chk("StallF", hIf.StallF, s);
      chk("StallD", hIf.StallD, s);
      chk("FlushE", hIf.FlushE, s);
      chk("FlushD", hIf.FlushD, (hIf.PCSrcD || hIf.JumpD) && !s);
      chk("MdBusy", hIf.MdBusy, mdRem > 0);
      chk("StallCount", hIf.StallCount, cntExp);
    end
  end

  task automatic clearIn();
    hIf.RsD = '0; hIf.RtD = '0; hIf.RsE = '0; hIf.RtE = '0;
    hIf.WriteRegE = '0; hIf.WriteRegM = '0; hIf.WriteRegW = '0;
    hIf.RegWriteE = 1'b0; hIf.RegWriteM = 1'b0; hIf.RegWriteW = 1'b0;
    hIf.MemtoRegE = 1'b0; hIf.MemtoRegM = 1'b0;
    hIf.BranchD = 1'b0; hIf.PCSrcD = 1'b0; hIf.JumpD = 1'b0;
    hIf.MdStartE = 1'b0; hIf.MdUseD = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadUseStall();
    hIf.MemtoRegE = 1'b1; hIf.WriteRegE = 5'd1; hIf.RsD = 5'd1;
  endtask

  initial begin
    clearIn();
    reset = 1'b0;
    #2;
    chk("rst_MdBusy", hIf.MdBusy, 0);
    chk("rst_StallCount", hIf.StallCount, 0);
    step();
    step();
    reset = 1'b1;
    cmpEn = 1'b1;

    // EX forwarding priority
    step();
    hIf.RsE = 5'd3; hIf.WriteRegM = 5'd3; hIf.RegWriteM = 1'b1;
    hIf.WriteRegW = 5'd3; hIf.RegWriteW = 1'b1;
    #1 chk("fwd_mem_prio", hIf.ForwardAE, 2);
    hIf.WriteRegM = 5'd5;
    #1 chk("fwd_wb", hIf.ForwardAE, 1);
    hIf.WriteRegM = 5'd0; hIf.WriteRegW = 5'd0;
    #1 chk("fwd_r0_none", hIf.ForwardAE, 0);

    // Load-use stall for one cycle
    step();
    clearIn();
    hIf.MemtoRegE = 1'b1; hIf.WriteRegE = 5'd4; hIf.RtD = 5'd4;
    #1 chk("lw_StallF", hIf.StallF, 1);
    chk("lw_StallD", hIf.StallD, 1);
    chk("lw_FlushE", hIf.FlushE, 1);
    chk("lw_cnt_before", hIf.StallCount, 0);
    step();
    clearIn();
    #1 chk("lw_release", hIf.StallF, 0);
    chk("lw_cnt_after", hIf.StallCount, 1);

    // Branch on an ALU result still in E, then forwarded from M
    hIf.BranchD = 1'b1; hIf.RsD = 5'd7; hIf.RegWriteE = 1'b1; hIf.WriteRegE = 5'd7;
    #1 chk("br_stall", hIf.StallF, 1);
    chk("br_FlushD_held", hIf.FlushD, 0);
    step();
    clearIn();
    hIf.BranchD = 1'b1; hIf.RsD = 5'd7; hIf.RegWriteM = 1'b1; hIf.WriteRegM = 5'd7;
    #1 chk("br_ForwardAD", hIf.ForwardAD, 1);
    chk("br_no_stall", hIf.StallF, 0);
    hIf.PCSrcD = 1'b1;
    #1 chk("br_taken_flush", hIf.FlushD, 1);

    // MULT/DIV interlock: issue cycle + MDL-1 busy cycles
    step();
    clearIn();
    hIf.MdStartE = 1'b1; hIf.MdUseD = 1'b1;
    #1 chk("md_issue_stall", hIf.StallF, 1);
    chk("md_issue_busy", hIf.MdBusy, 0);
    step();
    hIf.MdStartE = 1'b0;
    for (int i = 0; i < MDL - 1; i++) begin
      #1 chk("md_busy", hIf.MdBusy, 1);
      chk("md_stall", hIf.StallF, 1);
      step();
    end
    #1 chk("md_idle", hIf.MdBusy, 0);
    chk("md_released", hIf.StallF, 0);
    chk("md_cnt", hIf.StallCount, 6);

    // Jump flush gated by stall
    clearIn();
    hIf.JumpD = 1'b1; hIf.MemtoRegE = 1'b1; hIf.WriteRegE = 5'd2; hIf.RsD = 5'd2;
    #1 chk("jump_stalled", hIf.FlushD, 0);
    hIf.MemtoRegE = 1'b0;
    #1 chk("jump_flush", hIf.FlushD, 1);

    // Counter saturation at 4 bits
    step();
    clearIn();
    loadUseStall();
    repeat (9) step();
    chk("cnt_reach_max", hIf.StallCount, 15);
    repeat (11) step();
    chk("cnt_saturate", hIf.StallCount, 15);

    // Async reset mid MULT/DIV clears state without a clock edge
    reset = 1'b0;
    clearIn();
    step();
    reset = 1'b1;
    loadUseStall();
    repeat (9) step();
    clearIn();
    hIf.MdStartE = 1'b1;
    step();
    hIf.MdStartE = 1'b0;
    step();
    chk("pre_rst_busy", hIf.MdBusy, 1);
    chk("pre_rst_cnt", hIf.StallCount, 9);
    reset = 1'b0;
    #1 chk("async_rst_busy", hIf.MdBusy, 0);
    chk("async_rst_cnt", hIf.StallCount, 0);
    step();
    reset = 1'b1;

    // Randomized traffic with small register range for frequent hits
    for (int n = 0; n < 3000; n++) begin
      step();
      hIf.RsD = AW'($urandom_range(0, 3)); hIf.RtD = AW'($urandom_range(0, 3));
      hIf.RsE = AW'($urandom_range(0, 3)); hIf.RtE = AW'($urandom_range(0, 3));
      hIf.WriteRegE = AW'($urandom_range(0, 3));
      hIf.WriteRegM = AW'($urandom_range(0, 3));
      hIf.WriteRegW = AW'($urandom_range(0, 3));
      hIf.RegWriteE = 1'($urandom_range(0, 1)); hIf.RegWriteM = 1'($urandom_range(0, 1));
      hIf.RegWriteW = 1'($urandom_range(0, 1));
      hIf.MemtoRegE = ($urandom_range(0, 3) == 0); hIf.MemtoRegM = ($urandom_range(0, 3) == 0);
      hIf.BranchD = ($urandom_range(0, 3) == 0); hIf.PCSrcD = 1'($urandom_range(0, 1));
      hIf.JumpD = ($urandom_range(0, 7) == 0);
      hIf.MdStartE = ($urandom_range(0, 9) == 0);
      hIf.MdUseD = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        hIf.MdStartE = 1'b0;
      end else begin
        reset = 1'b1;
      end
    end

    step();
    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
